blk_0b4f7c: RTL
===============

// Module: axi_switch_0_ref_example_example_srl_fifo_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one reg_srl_fifo input among NUM_SI requesters.
//  Grants one source at a time, passes its beats to the FIFO until tlast or the beat limit.
//  Uses the FIFO almost-full flag to hold off new grants.
//  Sits between switch slave-side ports and the shared SRL FIFO write port.
// PARAMETERS
//  NUM_SI     4   number of requesting sources (2..16)
//  DATA_W     8   payload width per source (matches FIFO s_mesg width)
//  MAX_BEATS  16  beats per grant before forced release (>=1)
// PORTS
//  aclk       in   1              clock, all logic rising-edge
//  areset     in   1              synchronous active-high reset
//  aclken     in   1              clock enable; no state change or handshake when low
//  s_valid    in   NUM_SI         per-source valid
//  s_mesg     in   NUM_SI*DATA_W  per-source payload, source i at [i*DATA_W +: DATA_W]
//  s_last     in   NUM_SI         per-source end-of-packet
//  s_ready    out  NUM_SI         per-source ready
//  f_mesg     out  DATA_W         payload to FIFO s_mesg
//  f_valid    out  1              to FIFO s_valid
//  f_ready    in   1              from FIFO s_ready
//  f_afull    in   1              from FIFO s_afull
//  grant      out  NUM_SI         one-hot current owner, 0 when idle
//  busy       out  1              high in GRANTED state
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0; s_ready=0, f_valid=0, busy=0; f_mesg don't-care.
//  Reset mid-packet: the packet is abandoned with no flush. The source restarts arbitration.
//  Transfer (beat) = f_valid & f_ready & aclken. State updates only when aclken=1.
//  FSM IDLE:
//   - If |s_valid & ~f_afull: pick the first requester at or after rr_ptr (modulo NUM_SI).
//   - Register its one-hot grant and go to GRANTED.
//   - Otherwise stay in IDLE.
//   - f_valid=0 and s_ready=0 in IDLE. Grant-to-first-beat latency is 1 cycle.
//  FSM GRANTED (owner g):
//   - f_valid=s_valid[g], f_mesg=s_mesg[g], s_ready[g]=f_ready. Other s_ready bits are 0.
//   - This path is combinational and adds zero latency.
//   - Each beat increments beat_cnt.
//   - On a beat with s_last[g]=1, or a beat with beat_cnt==MAX_BEATS-1:
//     go to IDLE, set grant=0, beat_cnt=0, rr_ptr=(g+1) mod NUM_SI.
//     This gives exactly one idle bubble between grants.
//  f_afull is sampled only in IDLE. It never truncates a granted packet.
//  FIFO overflow is prevented by f_ready.
//  Simultaneous requests: the rotating priority guarantees each requester waits at most
//  NUM_SI-1 grants.
//  A request withdrawn in GRANTED (s_valid[g] drops) keeps the grant. The arbiter waits.
//  beat_cnt width is $clog2(MAX_BEATS+1). It never wraps because release happens at MAX_BEATS-1.
//  rr_ptr wraps NUM_SI-1 -> 0. For non-power-of-2 NUM_SI it never holds an illegal value.
//  Assertions:
//   - grant is onehot0.
//   - s_ready is onehot0 and a subset of grant.
//   - f_valid implies busy.
// STRUCTURE
//  Package axi_switch_0_ref_example_example_arb_pkg:
//   - t_arb_state enum {IDLE, GRANTED}.
//   - clog2-derived width constants.
//  Sub-module axi_switch_0_ref_example_example_rr_pick:
//   - Combinational rotate / priority-encode / unrotate.
//   - Inputs: req[NUM_SI], ptr. Output: onehot gnt.
//  Top level holds the FSM, rr_ptr, beat_cnt, the mux to f_mesg, and the s_ready fan-out.
// TESTING
//  1. Reset: assert areset 3 cycles with all s_valid=1 -> grant=0, s_ready=0, f_valid=0;
//     first grant=4'b0001 one cycle after release.
//  2. All 4 sources send 1-beat packets (s_last=1) continuously, f_ready=1 -> grant order
//     0,1,2,3,0; each beat followed by 1 idle cycle.
//  3. Source 2 sends a 40-beat packet, MAX_BEATS=16, source 3 also requesting ->
//     release after 16 beats, source 3 granted, source 2 regranted after source 3 finishes.
//  4. f_afull=1 while all sources request in IDLE -> no grant;
//     f_afull drops -> grant next cycle.
//     f_afull rising mid-packet -> packet completes.
//  5. Source 1 granted, f_ready toggles 1010 and s_valid[1] drops for 2 cycles ->
//     payload 8'hA0..8'hA5 arrives in order, no duplication or loss, grant held throughout.
//  6. aclken=0 for 5 cycles mid-packet -> no beats counted, state/grant/rr_ptr frozen;
//     resumes identically.

Source files
------------

// File: rtl/blk_0b4f7c_pkg.sv
// Shared types and width helpers for the packet round-robin arbiter that feeds the SRL FIFO.
package blk_0b4f7c_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } t_arb_state;

  localparam int NUM_SI_DEF    = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BEATS_DEF = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Beat counter width; holds 0..max_beats.
  function automatic int cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/blk_0b4f7c_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, modulo NUM_SI, as one-hot.
module blk_0b4f7c_rr_pick
  import blk_0b4f7c_pkg::*;
#(
  parameter int NUM_SI = NUM_SI_DEF,
  parameter int PTR_W  = idx_w(NUM_SI)
) (
  input  logic [NUM_SI-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_SI-1:0] gnt_o
);

  logic [NUM_SI-1:0] req_rot;
  logic [NUM_SI-1:0] gnt_rot;

  // Rotate so ptr_i lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_rot = NUM_SI'({req_i, req_i} >> ptr_i);
    gnt_rot = req_rot & (~req_rot + NUM_SI'(1));
    gnt_o   = NUM_SI'(({gnt_rot, gnt_rot} << ptr_i) >> NUM_SI);
  end

endmodule

// File: rtl/blk_0b4f7c.sv
// Packet-granular round-robin arbiter sharing one SRL FIFO write port among NUM_SI sources.
module blk_0b4f7c
  import blk_0b4f7c_pkg::*;
#(
  parameter int NUM_SI    = NUM_SI_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic                     aclk_i,
  input  logic                     areset_i,
  input  logic                     aclken_i,
  input  logic [NUM_SI-1:0]        s_valid_i,
  input  logic [NUM_SI*DATA_W-1:0] s_mesg_i,
  input  logic [NUM_SI-1:0]        s_last_i,
  output logic [NUM_SI-1:0]        s_ready_o,
  output logic [DATA_W-1:0]        f_mesg_o,
  output logic                     f_valid_o,
  input  logic                     f_ready_i,
  input  logic                     f_afull_i,
  output logic [NUM_SI-1:0]        grant_o,
  output logic                     busy_o
);

  localparam int PTR_W = idx_w(NUM_SI);
  localparam int CNT_W = cnt_w(MAX_BEATS);

  t_arb_state        state_q, state_d;
  logic [NUM_SI-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [NUM_SI-1:0]             pick_gnt;
  logic [NUM_SI-1:0][DATA_W-1:0] mesg_arr;
  logic [PTR_W-1:0]              owner_idx;
  logic [PTR_W-1:0]              next_ptr;
  logic                          owner_valid;
  logic                          owner_last;
  logic                          beat;

  assign mesg_arr = s_mesg_i;

  blk_0b4f7c_rr_pick #(
    .NUM_SI (NUM_SI),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req_i  (s_valid_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt)
  );

  // Owner-side view: AND-OR mux keyed by the one-hot grant.
  always_comb begin
    f_mesg_o  = '0;
    owner_idx = '0;
    for (int i = 0; i < NUM_SI; i++) begin
      if (grant_q[i]) begin
        f_mesg_o  = f_mesg_o | mesg_arr[i];
        owner_idx = PTR_W'(i);
      end
    end
    owner_valid = |(s_valid_i & grant_q);
    owner_last  = |(s_last_i & grant_q);
    next_ptr    = (owner_idx == PTR_W'(NUM_SI - 1)) ? '0 : owner_idx + PTR_W'(1);
  end

  // Next-state and handshake outputs; nothing handshakes while aclken_i is low.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    busy_o     = (state_q == GRANTED);
    f_valid_o  = 1'b0;
    s_ready_o  = '0;
    beat       = 1'b0;

    case (state_q)
      IDLE: begin
        if (aclken_i && (|s_valid_i) && !f_afull_i) begin
          state_d    = GRANTED;
          grant_d    = pick_gnt;
          beat_cnt_d = '0;
        end
      end
      GRANTED: begin
        f_valid_o = aclken_i & owner_valid;
        s_ready_o = (aclken_i && f_ready_i) ? grant_q : '0;
        beat      = f_valid_o & f_ready_i;
        if (beat) begin
          // Release on end of packet or at the beat limit; counter never wraps.
          if (owner_last || (beat_cnt_q == CNT_W'(MAX_BEATS - 1))) begin
            state_d    = IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = next_ptr;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else if (aclken_i) begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_o = grant_q;

  a_grant_onehot0: assert property (@(posedge aclk_i) disable iff (areset_i)
    $onehot0(grant_q));
  a_ready_subset: assert property (@(posedge aclk_i) disable iff (areset_i)
    $onehot0(s_ready_o) && ((s_ready_o & ~grant_q) == '0));
  a_valid_busy: assert property (@(posedge aclk_i) disable iff (areset_i)
    f_valid_o |-> busy_o);

endmodule
